// File: rtl/mem_subsys.sv
// Zero-wait memory subsystem: word RAM plus an MMIO window holding a TX byte FIFO,
// a free-running cycle timer and a saturating drop counter.
module mem_subsys #(
  parameter int unsigned                WIDTH      = 32,
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter int unsigned                RAM_WORDS  = 256,
  parameter int unsigned                FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0]      MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic [ADDR_WIDTH-1:0] memaddr_i,
  input  logic [WIDTH-1:0]      memwdata_i,
  output logic [WIDTH-1:0]      memrdata_o,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;

  logic [WIDTH-1:0] r_ram  [RAM_WORDS];
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_timer;
  logic [WIDTH-1:0] r_dropcnt;

  logic              w_is_ram, w_is_mmio;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [1:0]        w_off;
  logic              w_wr_ram, w_wr_tx, w_wr_timer, w_wr_drop;
  logic              w_empty, w_full, w_pop, w_push, w_drop;
  logic [WIDTH-1:0]  w_txstat;
  logic [WIDTH-1:0]  w_rdata;

  assign w_is_ram   = memaddr_i < ADDR_WIDTH'(RAM_WORDS * 4);
  assign w_is_mmio  = memaddr_i[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4];
  assign w_ram_idx  = memaddr_i[RAM_AW+1:2];
  assign w_off      = memaddr_i[3:2];

  assign w_wr_ram   = memwrite_i & w_is_ram;
  assign w_wr_tx    = memwrite_i & ~w_is_ram & w_is_mmio & (w_off == 2'd0);
  assign w_wr_timer = memwrite_i & ~w_is_ram & w_is_mmio & (w_off == 2'd2);
  assign w_wr_drop  = memwrite_i & ~w_is_ram & w_is_mmio & (w_off == 2'd3);

  assign w_empty    = r_count == '0;
  assign w_full     = r_count == CW'(FIFO_DEPTH);
  assign w_pop      = ~w_empty & tx_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_wr_tx & (~w_full | w_pop);
  assign w_drop     = w_wr_tx & ~w_push;

  assign tx_valid_o = ~w_empty;
  assign tx_data_o  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign w_txstat   = WIDTH'({r_count, w_empty, w_full});

  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[w_ram_idx] <= memwdata_i;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= memwdata_i[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer   <= '0;
      r_dropcnt <= '0;
    end else begin
      if (w_wr_timer) r_timer <= memwdata_i;
      else            r_timer <= r_timer + WIDTH'(1);
      if (w_wr_drop)                      r_dropcnt <= '0;
      else if (w_drop && r_dropcnt != '1) r_dropcnt <= r_dropcnt + WIDTH'(1);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (memread_i) begin
      if (w_is_ram) begin
        w_rdata = r_ram[w_ram_idx];
      end else if (w_is_mmio) begin
        case (w_off)
          2'd1:    w_rdata = w_txstat;
          2'd2:    w_rdata = r_timer;
          2'd3:    w_rdata = r_dropcnt;
          default: w_rdata = '0;
        endcase
      end
    end
  end

  assign memrdata_o = w_rdata;

endmodule

// File: tb/tb_mem_subsys.sv
// Directed and scoreboarded checks of mem_subsys RAM, TX FIFO, timer and drop counter.
module tb_mem_subsys;

  localparam logic [31:0] A_TX    = 32'hFFFF_FF00;
  localparam logic [31:0] A_STAT  = 32'hFFFF_FF04;
  localparam logic [31:0] A_TIMER = 32'hFFFF_FF08;
  localparam logic [31:0] A_DROP  = 32'hFFFF_FF0C;

  logic        clk;
  logic        rst;
  logic        memread, memwrite;
  logic [31:0] memaddr, memwdata;
  logic [31:0] memrdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_pass  = 0;
  int n_total = 0;

  mem_subsys #(
    .WIDTH      (32),
    .ADDR_WIDTH (32),
    .RAM_WORDS  (256),
    .FIFO_DEPTH (4),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memread_i  (memread),
    .memwrite_i (memwrite),
    .memaddr_i  (memaddr),
    .memwdata_i (memwdata),
    .memrdata_o (memrdata),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr  = a;
    memwdata = d;
    memwrite = 1'b1;
    step();
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memaddr = a;
    memread = 1'b1;
    #1;
    d = memrdata;
    memread = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", tx_data); else n_pass++;
    rd(A_TIMER, d);
    n_total++; if (d !== 32'h0) $display("FAIL rst_timer got=%h exp=0", d); else n_pass++;
    rd(A_STAT, d);
    n_total++; if (d !== 32'h2) $display("FAIL rst_stat got=%h exp=2", d); else n_pass++;
    #1;
    n_total++; if (memrdata !== 32'h0) $display("FAIL rst_rdata_idle got=%h exp=0", memrdata); else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, d);
    n_total++; if (d !== 32'hDEAD_BEEF) $display("FAIL ram_rd10 got=%h exp=deadbeef", d); else n_pass++;
    rd(32'h13, d);
    n_total++; if (d !== 32'hDEAD_BEEF) $display("FAIL ram_rd13 got=%h exp=deadbeef", d); else n_pass++;
    rd(32'h2000, d);
    n_total++; if (d !== 32'h0) $display("FAIL unmapped_rd got=%h exp=0", d); else n_pass++;
    memaddr = 32'h10;
    #1;
    n_total++; if (memrdata !== 32'h0) $display("FAIL rd_idle got=%h exp=0", memrdata); else n_pass++;
    wr(32'h20, 32'hAAAA_5555);
    memaddr = 32'h20; memwdata = 32'h1111_2222; memwrite = 1'b1; memread = 1'b1;
    #1;
    n_total++; if (memrdata !== 32'hAAAA_5555) $display("FAIL rdw_old got=%h exp=aaaa5555", memrdata); else n_pass++;
    step();
    memwrite = 1'b0; memread = 1'b0;
    rd(32'h20, d);
    n_total++; if (d !== 32'h1111_2222) $display("FAIL rdw_new got=%h exp=11112222", d); else n_pass++;
    wr(32'h0, 32'h0101_0101);
    wr(32'h2000, 32'h0000_0BAD);
    rd(32'h0, d);
    n_total++; if (d !== 32'h0101_0101) $display("FAIL unmapped_wr_alias got=%h exp=01010101", d); else n_pass++;
  endtask

  task automatic test_fifo_fill();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(A_TX, 32'hABCD_EF00 | (32'h41 + i));
    rd(A_STAT, d);
    n_total++; if (d !== 32'h11) $display("FAIL fill_stat got=%h exp=11", d); else n_pass++;
    rd(A_DROP, d);
    n_total++; if (d !== 32'h1) $display("FAIL fill_drop got=%h exp=1", d); else n_pass++;
    rd(A_TX, d);
    n_total++; if (d !== 32'h0) $display("FAIL txdata_rd got=%h exp=0", d); else n_pass++;
    step();
    n_total++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) $display("FAIL hold_head got=%b/%h exp=1/41", tx_valid, tx_data); else n_pass++;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (tx_data !== 8'(8'h41 + i)) $display("FAIL drain%0d got=%h exp=%h", i, tx_data, 8'(8'h41 + i)); else n_pass++;
      step();
    end
    n_total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL drain_empty got=%b/%h exp=0/00", tx_valid, tx_data); else n_pass++;
    rd(A_STAT, d);
    n_total++; if (d !== 32'h2) $display("FAIL drain_stat got=%h exp=2", d); else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    logic [7:0]  exp_b [4];
    exp_b[0] = 8'h62; exp_b[1] = 8'h63; exp_b[2] = 8'h64; exp_b[3] = 8'h55;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h61 + i);
    tx_ready = 1'b1;
    memaddr = A_TX; memwdata = 32'h55; memwrite = 1'b1;
    #1;
    n_total++; if (tx_data !== 8'h61) $display("FAIL pp_head got=%h exp=61", tx_data); else n_pass++;
    step();
    memwrite = 1'b0;
    rd(A_STAT, d);
    n_total++; if (d !== 32'h11) $display("FAIL pp_stat got=%h exp=11", d); else n_pass++;
    rd(A_DROP, d);
    n_total++; if (d !== 32'h1) $display("FAIL pp_drop got=%h exp=1", d); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (tx_data !== exp_b[i]) $display("FAIL pp_out%0d got=%h exp=%h", i, tx_data, exp_b[i]); else n_pass++;
      step();
    end
    n_total++; if (tx_valid !== 1'b0) $display("FAIL pp_empty got=%b exp=0", tx_valid); else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_timer();
    logic [31:0] d;
    wr(A_TIMER, 32'hFFFF_FFFE);
    rd(A_TIMER, d);
    n_total++; if (d !== 32'hFFFF_FFFE) $display("FAIL timer_load got=%h exp=fffffffe", d); else n_pass++;
    step();
    rd(A_TIMER, d);
    n_total++; if (d !== 32'hFFFF_FFFF) $display("FAIL timer_inc got=%h exp=ffffffff", d); else n_pass++;
    step();
    rd(A_TIMER, d);
    n_total++; if (d !== 32'h0) $display("FAIL timer_wrap got=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_TX, 32'h31 + i);
    n_total++; if (tx_valid !== 1'b1) $display("FAIL pre_rst_valid got=%b exp=1", tx_valid); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL midrst_tx got=%b/%h exp=0/00", tx_valid, tx_data); else n_pass++;
    rd(A_TIMER, d);
    n_total++; if (d !== 32'h0) $display("FAIL midrst_timer got=%h exp=0", d); else n_pass++;
    rd(A_DROP, d);
    n_total++; if (d !== 32'h0) $display("FAIL midrst_drop got=%h exp=0", d); else n_pass++;
    rst = 1'b1;
    step();
    rd(32'h10, d);
    n_total++; if (d !== 32'hDEAD_BEEF) $display("FAIL ram_kept got=%h exp=deadbeef", d); else n_pass++;
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wr(A_STAT, 32'hFFFF_FFFF);
    rd(A_STAT, d);
    n_total++; if (d !== 32'h2) $display("FAIL stat_ro got=%h exp=2", d); else n_pass++;
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(A_TX, 32'h71 + i);
    rd(A_DROP, d);
    n_total++; if (d !== 32'h2) $display("FAIL drop2 got=%h exp=2", d); else n_pass++;
    wr(A_DROP, 32'h1234);
    rd(A_DROP, d);
    n_total++; if (d !== 32'h0) $display("FAIL drop_clr got=%h exp=0", d); else n_pass++;
    tx_ready = 1'b1;
    repeat (4) step();
    rd(A_STAT, d);
    n_total++; if (d !== 32'h2) $display("FAIL regs_empty got=%h exp=2", d); else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ram_m [16];
    logic [7:0]  q [$];
    logic [31:0] d, v;
    int unsigned op, idx;
    int          pushes, drops, nout;
    logic        pop;
    pushes = 0; drops = 0; nout = 0;
    for (int i = 0; i < 16; i++) begin
      ram_m[i] = $urandom;
      wr(32'h100 + 32'(i * 4), ram_m[i]);
    end
    for (int n = 0; n < 400; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 3);
      idx = $urandom_range(0, 15);
      #1;
      n_total++; if (tx_valid !== (q.size() != 0)) $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, tx_valid, q.size() != 0); else n_pass++;
      if (q.size() != 0) begin
        n_total++; if (tx_data !== q[0]) $display("FAIL rnd_data n=%0d got=%h exp=%h", n, tx_data, q[0]); else n_pass++;
      end
      pop = (q.size() != 0) && tx_ready;
      case (op)
        0: begin
          v = $urandom;
          memaddr = 32'h100 + 32'(idx * 4); memwdata = v; memwrite = 1'b1;
          ram_m[idx] = v;
        end
        1: begin
          rd(32'h100 + 32'(idx * 4), d);
          n_total++; if (d !== ram_m[idx]) $display("FAIL rnd_ram n=%0d got=%h exp=%h", n, d, ram_m[idx]); else n_pass++;
        end
        2: begin
          v = $urandom;
          memaddr = A_TX; memwdata = v; memwrite = 1'b1;
          pushes++;
          if (q.size() < 4 || pop) q.push_back(v[7:0]);
          else drops++;
        end
        default: begin
          rd(32'h1000 + (32'($urandom) & 32'hFF0), d);
          n_total++; if (d !== 32'h0) $display("FAIL rnd_unmapped n=%0d got=%h exp=0", n, d); else n_pass++;
        end
      endcase
      if (pop) begin
        // Popped head is the entry that was at q[0] before any push this cycle.
        if (op == 2 && q.size() == 5) void'(q.pop_front());
        else void'(q.pop_front());
        nout++;
      end
      step();
      memwrite = 1'b0;
    end
    rd(A_DROP, d);
    n_total++; if (d !== 32'(drops)) $display("FAIL rnd_dropcnt got=%0d exp=%0d", d, drops); else n_pass++;
    n_total++; if (32'(nout) + 32'(q.size()) + d !== 32'(pushes)) $display("FAIL rnd_conserve got=%0d exp=%0d", 32'(nout) + 32'(q.size()) + d, pushes); else n_pass++;
    rd(A_STAT, d);
    v = {27'h0, 3'(q.size()), q.size() == 0, q.size() == 4};
    n_total++; if (d !== v) $display("FAIL rnd_stat got=%h exp=%h", d, v); else n_pass++;
  endtask

  initial begin
    rst = 1'b0; memread = 1'b0; memwrite = 1'b0;
    memaddr = '0; memwdata = '0; tx_ready = 1'b0;
    test_reset();
    test_ram();
    test_fifo_fill();
    test_push_pop_full();
    test_timer();
    test_reset_mid();
    test_regs();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
